// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiply sequencer.
package mul_pkg;

  // Operation select, matching funct3[1:0] of the RV32M multiply group.
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  // Sequencer states. MUL lasts 32 cycles, every other non-IDLE state lasts one.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    MUL    = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    RESP   = 3'd6
  } mul_state_e;

  // Edges from the accepting edge to the rise of rsp_valid_o.
  localparam int MUL_LATENCY = 36;

endpackage

// File: rtl/core_adder.sv
// Plain 32-bit two-operand adder with no carry-in and no carry-out.
// The sequencer time-multiplexes this single instance for every step.
module core_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative RV32M multiply sequencer (MUL, MULH, MULHSU, MULHU).
// Signed operands are converted to magnitudes, multiplied by shift-add over
// 32 cycles, and the 64-bit product is conditionally negated in two halves.
// One shared core_adder does all arithmetic, so the latency is fixed at 36.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,  // only 32 is legal: core_adder is fixed at 32 bits
  parameter int CNT_W = 5    // log2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  mul_state_e       state_q, state_d;
  mul_op_e          op_q;
  logic [XLEN-1:0]  a_q;       // multiplicand, becomes |A| after ABS_A
  logic [XLEN-1:0]  hi_q;      // upper product word / partial-sum accumulator
  logic [XLEN-1:0]  lo_q;      // multiplier, shifted out as product low word fills in
  logic [CNT_W-1:0] cnt_q;
  logic             sa_q, sb_q, neg_q, c_q;

  logic             accept;
  logic             sa, sb;
  logic [XLEN-1:0]  add_a, add_b, sum;
  logic             carry;

  assign accept = (state_q == IDLE) && req_valid_i;

  // Operand signs: rs1 is signed for MULH/MULHSU, rs2 only for MULH.
  assign sa = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && a_i[XLEN-1];
  assign sb = (op_i == OP_MULH) && b_i[XLEN-1];

  // The adder has no carry-out; an unsigned wrap shows up as sum < hi.
  assign carry = (sum < hi_q);

  core_adder u_adder (
    .a_i  (add_a),
    .b_i  (add_b),
    .sum_o(sum)
  );

  // Adder operand mux, driven purely by state; idle in IDLE and RESP.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise the
    // states that do not assign it would infer a latch.
    add_a = '0;
    add_b = '0;
    unique case (state_q)
      ABS_A:  begin add_a = ~a_q;  add_b = XLEN'(1);      end
      ABS_B:  begin add_a = ~lo_q; add_b = XLEN'(1);      end
      MUL:    begin add_a = hi_q;  add_b = lo_q[0] ? a_q : '0; end
      NEG_LO: begin add_a = ~lo_q; add_b = XLEN'(1);      end
      NEG_HI: begin add_a = ~hi_q; add_b = XLEN'(c_q);    end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; flush outranks completion and the response handshake.
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (req_valid_i) state_d = ABS_A;
        ABS_A:   state_d = ABS_B;
        ABS_B:   state_d = MUL;
        MUL:     if (cnt_q == '1) state_d = NEG_LO;
        NEG_LO:  state_d = NEG_HI;
        NEG_HI:  state_d = RESP;
        RESP:    if (rsp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers: operand capture, magnitude, shift-add, negate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= OP_MUL;
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      neg_q <= 1'b0;
      c_q   <= 1'b0;
    end else if (accept) begin
      op_q  <= mul_op_e'(op_i);
      a_q   <= a_i;
      lo_q  <= b_i;
      hi_q  <= '0;
      cnt_q <= '0;
      sa_q  <= sa;
      sb_q  <= sb;
      neg_q <= sa ^ sb;
      c_q   <= 1'b0;
    end else if (!flush_i) begin
      unique case (state_q)
        ABS_A:  if (sa_q) a_q <= sum;
        ABS_B:  if (sb_q) lo_q <= sum;
        MUL: begin
          {hi_q, lo_q} <= {carry, sum, lo_q[XLEN-1:1]};
          cnt_q        <= cnt_q + 1'b1;
        end
        NEG_LO: if (neg_q) begin
          lo_q <= sum;
          c_q  <= (lo_q == '0);
        end
        NEG_HI: if (neg_q) hi_q <= sum;
        default: ;
      endcase
    end else begin
      // A flushed operation must not leave the iteration count mid-way.
      cnt_q <= '0;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign result_o    = (state_q != RESP) ? '0 : (op_q == OP_MUL) ? lo_q : hi_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl.
module tb_mul_seq_ctrl;
  import mul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] result_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_seq_ctrl dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .result_o   (result_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the response and check latency and
  // result. With rsp_ready_i high the return to IDLE is checked as well.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk_i);
    check({tag, " req_ready"}, 32'(req_ready_o), 32'd1);
    op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check({tag, " busy"}, 32'(busy_o), 32'd1);
    n = 0;
    while (!rsp_valid_o && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(MUL_LATENCY));
    check({tag, " result"}, result_o, exp);
    if (rsp_ready_i) begin
      @(negedge clk_i);
      check({tag, " ready_after"}, 32'(req_ready_o), 32'd1);
      check({tag, " valid_after"}, 32'(rsp_valid_o), 32'd0);
    end
  endtask

  initial begin
    int hits;
    rst_ni = 1'b0; req_valid_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    flush_i = 1'b0; rsp_ready_i = 1'b1;

    #1;
    check("reset req_ready", 32'(req_ready_o), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset busy",      32'(busy_o),      32'd0);
    check("reset result",    result_o,         32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(OP_MUL,    32'd7,        32'd6,        32'h0000_002A, "mul 7x6");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu ffx ff");
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul ffxff");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh min");
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, "mulh -1x5");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(OP_MULH,   32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, "mulh zero neg");

    // Backpressure: response held for 5 cycles while a competing request waits.
    rsp_ready_i = 1'b0;
    run_op(OP_MULHU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, "stall");
    op_i = OP_MUL; a_i = 32'd2; b_i = 32'd2; req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("stall rsp_valid", 32'(rsp_valid_o), 32'd1);
      check("stall result",    result_o,         32'h0000_0003);
      check("stall req_ready", 32'(req_ready_o), 32'd0);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("stall release valid", 32'(rsp_valid_o), 32'd0);
    check("stall release busy",  32'(busy_o),      32'd0);
    check("stall release ready", 32'(req_ready_o), 32'd1);

    // Flush during MUL iteration 10 (the accept edge plus 12 more edges).
    op_i = OP_MUL; a_i = 32'd7; b_i = 32'd6; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (12) @(negedge clk_i);
    check("flush pre busy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("flush busy",      32'(busy_o),      32'd0);
    check("flush req_ready", 32'(req_ready_o), 32'd1);
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) hits++;
    end
    check("flush no response", 32'(hits), 32'd0);

    // Asynchronous reset pulse in the middle of MUL.
    op_i = OP_MULHU; a_i = 32'hFFFF_FFFF; b_i = 32'h1234_5678; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (15) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async rst req_ready", 32'(req_ready_o), 32'd1);
    check("async rst rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("async rst busy",      32'(busy_o),      32'd0);
    check("async rst result",    result_o,         32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(OP_MUL, 32'd3, 32'd3, 32'h0000_0009, "mul 3x3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative RV32M multiply sequencer: time-multiplexes one shared 32-bit adder (core_adder) to run MUL, MULH, MULHSU and MULHU.
- Sits beside the ALU in the execute stage and returns a 32-bit result.
- Uses a valid/ready request and response handshake and a fixed 36-cycle latency.
- Signed operations use sign-magnitude: absolute values in, shift-add product, conditional 64-bit negate.

Parameters:
- XLEN, 32, datapath width; only 32 is legal because the adder is fixed at 32 bits.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  high only in IDLE
- op_i  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
- a_i  input  32  rs1 operand (multiplicand)
- b_i  input  32  rs2 operand (multiplier)
- flush_i  input  1  synchronous abort of the in-flight operation
- rsp_valid_o  output  1  result valid; held until accepted
- rsp_ready_i  input  1  consumer ready
- result_o  output  32  product low word (MUL) or high word (other ops)
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset values (async on rst_ni low): state IDLE, req_ready_o=1, rsp_valid_o=0, busy_o=0, result_o=0, counter=0, all internal registers 0.
- Reset takes effect immediately, including mid-operation.
- Accept: on an edge with req_valid_i && req_ready_o, latch a_i, b_i and op_i. Compute neg_res = sA ^ sB.
  - sA = a_i[31] for MULH/MULHSU, else 0.
  - sB = b_i[31] for MULH only, else 0.
- FSM: IDLE -> ABS_A -> ABS_B -> MUL (32 cycles) -> NEG_LO -> NEG_HI -> RESP -> IDLE.
- ABS_A: if sA, A <= adder(~A, 1); else A unchanged. ABS_B does the same for B with sB.
- MUL: hi starts at 0 and lo = B.
  - Each cycle, s = adder(hi, lo[0] ? A : 0) and carry = (s < hi), unsigned compare (the adder has no carry-out).
  - Then {hi, lo} <= {carry, s, lo[31:1]}; counter increments and wraps 31->0, which exits to NEG_LO.
- NEG_LO: if neg_res, lo <= adder(~lo, 1) and c <= (lo == 0); otherwise unchanged.
- NEG_HI: if neg_res, hi <= adder(~hi, c); otherwise unchanged. Exactly one adder use per cycle.
- RESP: result_o = (op==MUL) ? lo : hi and rsp_valid_o = 1.
  - Leave on rsp_ready_i to IDLE; result_o remains stable while rsp_valid_o && !rsp_ready_i.
- Latency: rsp_valid_o rises exactly 36 edges after the accepting edge, independent of operands and sign.
- No new request is accepted in the cycle the response is consumed; req_ready_o rises the cycle after.
- flush_i in any non-IDLE state: next state IDLE, rsp_valid_o=0, result discarded. In IDLE it is ignored.
- flush_i has priority over rsp_ready_i and over completion.
- The adder input mux is purely combinational from state; the adder is never used in IDLE or RESP.
- Corner cases:
  - 0x80000000 magnitude remains 0x80000000, which is correct as unsigned.
  - A negated zero product yields 0 via the carry chain.

Decomposition:
- Shared package mul_pkg holds:
  - mul_op_e enum (MUL/MULH/MULHSU/MULHU = 2'b00..2'b11)
  - mul_state_e enum (IDLE, ABS_A, ABS_B, MUL, NEG_LO, NEG_HI, RESP)
  - constant MUL_LATENCY = 36
- One sub-module: the existing core_adder, instantiated once, with operand muxes in mul_seq_ctrl.

Test Plan:
- MUL a=7, b=6, rsp_ready_i=1 -> rsp_valid_o at edge 36 after accept, result_o=0x0000002A, then req_ready_o=1.
- MULHU a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE; MUL with the same operands -> result_o=0x00000001.
- MULH a=b=0x80000000 -> 0x40000000; MULH a=0xFFFFFFFF, b=0x00000005 -> 0xFFFFFFFF.
- MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULH a=0xFFFFFFFB, b=0 -> 0x00000000, exercising zero negate.
- Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid_o and result_o stable, req_ready_o=0, and a req_valid_i during the stall is not accepted.
- flush_i at MUL iteration 10 -> IDLE next cycle, no rsp_valid_o. rst_ni pulsed low mid-MUL -> all outputs at reset values immediately. A following MUL 3x3 -> 9.
